// File: rtl/multicycle_core_if.sv
// Instruction-fetch bus of multicycle_core: req/addr from the core, rdata/valid from memory.
interface multicycle_core_if #(
    parameter int unsigned PC_W = 10
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-ISA core: FETCH (stallable) -> EXEC -> FETCH/HALT, 8-entry regfile, r0 = 0.
// Optional MULTICYCLE_CORE_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_core #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_core_if.master imem,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted
`ifdef MULTICYCLE_CORE_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   rf_q [8];
    logic [DATA_W-1:0]   rf_d [8];

    logic [2:0]          op, rd, rs1, rs2;
    logic [DATA_W-1:0]   rd_val, rs1_val, rs2_val, imm4, alu;
    logic [PC_W-1:0]     br_off;
    logic                alu_op, take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   if (imem.imem_valid) state_d = EXEC;
            EXEC:    state_d = (op == 3'b111) ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Request is gated by reset so no fetch is visible while the core is held.
    always_comb begin
        imem.imem_req  = (state_q == FETCH) && reset;
        imem.imem_addr = pc_q;
        pc             = pc_q;
        retire         = (state_q == EXEC);
        halted         = (state_q == HALT);
    end

    always_comb begin
        op      = ir_q[15:13];
        rd      = ir_q[12:10];
        rs1     = ir_q[9:7];
        rs2     = ir_q[2:0];
        rd_val  = rf_q[rd];
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
        imm4    = DATA_W'(ir_q[3:0]);
        br_off  = PC_W'($signed(ir_q[6:0]));
        alu_op  = (op != 3'b011) && (op != 3'b111);
        take    = (op == 3'b011) && (rd_val == rs1_val);

        unique case (op)
            3'b000:  alu = rs1_val + rs2_val;
            3'b001:  alu = rs1_val + imm4;
            3'b010:  alu = rs1_val - imm4;
            3'b100:  alu = rs1_val - rs2_val;
            3'b101:  alu = rs1_val & rs2_val;
            3'b110:  alu = rs1_val | rs2_val;
            default: alu = '0;
        endcase
    end

    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        rf_d = rf_q;
        if (state_q == FETCH && imem.imem_valid) begin
            ir_d = imem.imem_rdata;
        end
        if (state_q == EXEC) begin
            if (op != 3'b111) begin
                pc_d = take ? pc_q + PC_W'(1) + br_off : pc_q + PC_W'(1);
            end
            // rf_q[0] is never written, so r0 reads as zero without a read-side mux.
            if (alu_op && rd != 3'd0) begin
                rf_d[rd] = alu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= PC_W'(RESET_PC);
            ir_q <= '0;
            rf_q <= '{default: '0};
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            rf_q <= rf_d;
        end
    end

`ifdef MULTICYCLE_CORE_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = (state_q != HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instret_cnt_d = (state_q == EXEC) ? instret_cnt_q + 32'd1 : instret_cnt_q;
        cycle_cnt     = cycle_cnt_q;
        instret_cnt   = instret_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: expected retire PCs are queued per program, a monitor
// pops one per retire pulse; a 16-bit and a 32-bit instance share the clock.
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16 = 1'b0;
    logic rst32 = 1'b0;

    multicycle_core_if #(.PC_W(10)) bus16 ();
    multicycle_core_if #(.PC_W(10)) bus32 ();

    logic [9:0] pc16, pc32;
    logic       retire16, retire32, halted16, halted32;
`ifdef MULTICYCLE_CORE_PERF_EN
    logic [31:0] cyc16, inst16, cyc32, inst32;
`endif

    multicycle_core #(.DATA_W(16), .PC_W(10), .RESET_PC(0)) dut16 (
        .clk(clk), .reset(rst16), .imem(bus16),
        .pc(pc16), .retire(retire16), .halted(halted16)
`ifdef MULTICYCLE_CORE_PERF_EN
        , .cycle_cnt(cyc16), .instret_cnt(inst16)
`endif
    );

    multicycle_core #(.DATA_W(32), .PC_W(10), .RESET_PC(5)) dut32 (
        .clk(clk), .reset(rst32), .imem(bus32),
        .pc(pc32), .retire(retire32), .halted(halted32)
`ifdef MULTICYCLE_CORE_PERF_EN
        , .cycle_cnt(cyc32), .instret_cnt(inst32)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cycle   = 0;
    logic [15:0] mem16 [1024];
    logic [15:0] mem32 [1024];
    int unsigned stall16  = 0;
    int unsigned period16 = 0;
    bit          late16   = 1'b0;
    logic [9:0]  q16 [$];
    logic [9:0]  q32 [$];
    logic [15:0] exp16 [8];
    logic [31:0] exp32 [8];

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [6:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rf16(input string tag, input logic [15:0] e [8]);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), 32'(dut16.rf_q[i]), 32'(e[i]));
    endtask

    task automatic check_rf32(input string tag, input logic [31:0] e [8]);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut32.rf_q[i], e[i]);
    endtask

    task automatic fill16();
        for (int i = 0; i < 1024; i++) mem16[i] = enc(3'd7, 3'd0, 3'd0, 7'd0);
    endtask

    task automatic load_a16();
        fill16();
        mem16[0] = enc(3'd1, 3'd1, 3'd0, 7'd5);   // ADDI r1,r0,5
        mem16[1] = enc(3'd1, 3'd2, 3'd0, 7'd3);   // ADDI r2,r0,3
        mem16[2] = enc(3'd0, 3'd3, 3'd1, 7'd2);   // ADD  r3,r1,r2
        mem16[3] = enc(3'd2, 3'd4, 3'd3, 7'd1);   // SUBI r4,r3,1
    endtask

    task automatic load_c16();
        fill16();
        mem16[0]  = enc(3'd1, 3'd1, 3'd0, 7'd4);    // ADDI r1,r0,4
        mem16[1]  = enc(3'd1, 3'd2, 3'd0, 7'd4);    // ADDI r2,r0,4
        mem16[2]  = enc(3'd1, 3'd3, 3'd0, 7'd15);   // ADDI r3,r0,15
        mem16[3]  = enc(3'd3, 3'd0, 3'd0, 7'd6);    // BEQ  r0,r0,+6 -> 10
        mem16[9]  = enc(3'd1, 3'd1, 3'd1, 7'd1);    // ADDI r1,r1,1
        mem16[10] = enc(3'd3, 3'd1, 3'd2, 7'h7E);   // BEQ  r1,r2,-2 -> 9 / 11
        mem16[11] = enc(3'd4, 3'd6, 3'd1, 7'd2);    // SUB  r6,r1,r2
        mem16[12] = enc(3'd6, 3'd5, 3'd1, 7'd2);    // OR   r5,r1,r2
        mem16[13] = enc(3'd5, 3'd7, 3'd5, 7'd2);    // AND  r7,r5,r2
        mem16[14] = enc(3'd4, 3'd4, 3'd2, 7'd1);    // SUB  r4,r2,r1
        mem16[15] = enc(3'd3, 3'd0, 3'd0, 7'h76);   // BEQ  r0,r0,-10 -> 6
    endtask

    task automatic reset16(input bit late, input int unsigned new_stall, input int unsigned new_period);
        @(posedge clk); #1;
        rst16    = 1'b0;
        late16   = late;
        stall16  = new_stall;
        period16 = new_period;
        @(posedge clk); @(negedge clk);
        check("rst16_req", 32'(bus16.imem_req), 0);
        check("rst16_pc", 32'(pc16), 0);
        check("rst16_halted", 32'(halted16), 0);
        check("rst16_retire", 32'(retire16), 0);
        check("rst16_ir", 32'(dut16.ir_q), 0);
        for (int i = 0; i < 8; i++) check($sformatf("rst16_r%0d", i), 32'(dut16.rf_q[i]), 0);
`ifdef MULTICYCLE_CORE_PERF_EN
        check("rst16_cycle_cnt", cyc16, 0);
        check("rst16_instret_cnt", inst16, 0);
`endif
        @(posedge clk); #1;
        late16 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst16_req_held", 32'(bus16.imem_req), 0);
        check("rst16_pc_held", 32'(pc16), 0);
        @(posedge clk); #1;
        rst16 = 1'b1;
        @(negedge clk);
        check("first_req", 32'(bus16.imem_req), 1);
        check("first_addr", 32'(bus16.imem_addr), 0);
    endtask

    task automatic wait_halt16(input int budget);
        int k = 0;
        while (!halted16 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("halt16_reached", 32'(halted16), 1);
        check("q16_drained", q16.size(), 0);
    endtask

    // Instruction memory for dut16: programmable wait states, optional stray valid during reset.
    initial begin : resp16
        int unsigned waited;
        logic [9:0]  held;
        waited = 0;
        held   = '0;
        bus16.imem_valid = 1'b0;
        bus16.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (late16) begin
                bus16.imem_valid = 1'b1;
                bus16.imem_rdata = enc(3'd1, 3'd7, 3'd0, 7'd9);
                waited = 0;
            end else if (bus16.imem_req) begin
                if (waited > 0) check("addr16_stable", 32'(bus16.imem_addr), 32'(held));
                held = bus16.imem_addr;
                if (waited >= stall16) begin
                    bus16.imem_valid = 1'b1;
                    bus16.imem_rdata = mem16[bus16.imem_addr];
                    waited = 0;
                end else begin
                    bus16.imem_valid = 1'b0;
                    waited++;
                end
            end else begin
                bus16.imem_valid = 1'b0;
                waited = 0;
            end
        end
    end

    initial begin : resp32
        bus32.imem_valid = 1'b0;
        bus32.imem_rdata = '0;
        forever begin
            @(negedge clk);
            bus32.imem_valid = bus32.imem_req;
            bus32.imem_rdata = mem32[bus32.imem_addr];
        end
    end

    initial begin : mon16
        int unsigned last;
        bit          have_last;
        logic [9:0]  exp;
        last      = 0;
        have_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst16) begin
                have_last = 1'b0;
            end else if (retire16) begin
                if (q16.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL retire16_unexpected: got retire at pc 0x%0h, expected none", pc16);
                end else begin
                    exp = q16.pop_front();
                    check("retire16_pc", 32'(pc16), 32'(exp));
                    if (have_last && period16 != 0) check("retire16_period", cycle - last, period16);
                end
                last      = cycle;
                have_last = 1'b1;
            end
        end
    end

    initial begin : mon32
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (rst32 && retire32) begin
                if (q32.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL retire32_unexpected: got retire at pc 0x%0h, expected none", pc32);
                end else begin
                    exp = q32.pop_front();
                    check("retire32_pc", 32'(pc32), 32'(exp));
                end
            end
        end
    end

    initial begin : main
        int k;
        for (int i = 0; i < 1024; i++) mem32[i] = enc(3'd7, 3'd0, 3'd0, 7'd0);
        mem32[5]      = enc(3'd2, 3'd1, 3'd0, 7'd1);    // SUBI r1,r0,1
        mem32[6]      = enc(3'd1, 3'd2, 3'd1, 7'd1);    // ADDI r2,r1,1
        mem32[7]      = enc(3'd1, 3'd0, 3'd0, 7'd7);    // ADDI r0,r0,7
        mem32[8]      = enc(3'd0, 3'd3, 3'd0, 7'd1);    // ADD  r3,r0,r1
        mem32[9]      = enc(3'd3, 3'd0, 3'd0, 7'h75);   // BEQ  r0,r0,-11 -> 0x3FF
        mem32[10'h3FF] = enc(3'd3, 3'd2, 3'd0, 7'd0);   // BEQ  r2,r0,0 -> wraps to 0

        // Program A, no wait states.
        load_a16();
        q16 = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
        reset16(1'b0, 0, 2);
        wait_halt16(200);
        exp16 = '{16'h0, 16'h5, 16'h3, 16'h8, 16'h7, 16'h0, 16'h0, 16'h0};
        check_rf16("progA", exp16);
        check("progA_pc", 32'(pc16), 4);

        // Program A, three wait states per fetch.
        q16 = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
        reset16(1'b0, 3, 5);
        wait_halt16(400);
        check_rf16("progA_stall", exp16);
        check("progA_stall_pc", 32'(pc16), 4);

        // Branches, SUB/AND/OR, HALT at pc 6.
        load_c16();
        q16 = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd10, 10'd9, 10'd10, 10'd11,
                10'd12, 10'd13, 10'd14, 10'd15, 10'd6};
        reset16(1'b0, 0, 2);
        wait_halt16(300);
        exp16 = '{16'h0, 16'h5, 16'h4, 16'hF, 16'hFFFF, 16'h5, 16'h1, 16'h4};
        check_rf16("progC", exp16);
`ifdef MULTICYCLE_CORE_PERF_EN
        check("halt_cycle_cnt", cyc16, 26);
        check("halt_instret_cnt", inst16, 13);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_req", 32'(bus16.imem_req), 0);
            check("halt_pc", 32'(pc16), 6);
            check("halt_flag", 32'(halted16), 1);
            check("halt_retire", 32'(retire16), 0);
        end
`ifdef MULTICYCLE_CORE_PERF_EN
        check("halt_cycle_cnt_frozen", cyc16, 26);
        check("halt_instret_cnt_frozen", inst16, 13);
`endif

        // Reset out of HALT, then reset again in the middle of a fetch stall.
        load_a16();
        q16 = '{10'd0, 10'd1};
        reset16(1'b0, 10, 12);
        k = 0;
        while (q16.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_q16_drained", q16.size(), 0);
        repeat (4) @(negedge clk);
        check("stall_req", 32'(bus16.imem_req), 1);
        check("stall_addr", 32'(bus16.imem_addr), 2);
        q16 = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
        reset16(1'b1, 0, 2);
        wait_halt16(200);
        exp16 = '{16'h0, 16'h5, 16'h3, 16'h8, 16'h7, 16'h0, 16'h0, 16'h0};
        check_rf16("after_late", exp16);

        // 32-bit instance: wrap-around, r0 write discard, PC wrap, RESET_PC=5.
        q32 = '{10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'h3FF, 10'd0};
        @(negedge clk);
        check("rst32_pc", 32'(pc32), 5);
        check("rst32_req", 32'(bus32.imem_req), 0);
        @(posedge clk); #1;
        rst32 = 1'b1;
        k = 0;
        while (!halted32 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("halt32_reached", 32'(halted32), 1);
        check("q32_drained", q32.size(), 0);
        check("halt32_pc", 32'(pc32), 0);
        exp32 = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        check_rf32("w32", exp32);
`ifdef MULTICYCLE_CORE_PERF_EN
        check("w32_cycle_cnt", cyc32, 14);
        check("w32_instret_cnt", inst32, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
